// File: rtl/fsm_seq_driver.sv
// fsm_seq_driver
//   Drives the 2-bit input of a 5-state Mealy control FSM (S0..S4) and checks
//   its 2-bit output against an internal cycle-accurate model of that FSM.
//   Each accepted command steers the FSM from its current state to a target
//   state along the shortest path. Every non-reset cycle the returned output
//   is compared with the model's output.
// Ports
//   clk, reset          clock; synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_target is the state index 0..4
//   fsm_input           drive to the FSM (combinational from registers only)
//   fsm_output          FSM Mealy output for the current fsm_input
//   busy                high while steering
//   done                1-cycle pulse when the target is reached
//   step_count          transitions used by the last command
//   cmd_err             1-cycle pulse after an illegal target is accepted
//   mismatch            1-cycle pulse, cycle after an output mismatch
//   err_count           saturating mismatch total since reset
module fsm_seq_driver #(
  parameter int CNT_W  = 8,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_target,
  output logic [1:0]        fsm_input,
  input  logic [1:0]        fsm_output,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_count,
  output logic              cmd_err,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic {IDLE, STEER} ctrl_e;

  // Input that keeps the FSM where it is. S3 has no self-loop; 00 lets it
  // drift to S2, which is accepted behaviour while idle.
  function automatic logic [1:0] hold_in(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: hold_in = 2'b10;
      default:    hold_in = 2'b00;
    endcase
  endfunction

  // First hop of the shortest path from cur to tgt.
  function automatic logic [1:0] route_in(input logic [2:0] cur, input logic [2:0] tgt);
    route_in = 2'b00;
    case (cur)
      3'd0: route_in = (tgt == 3'd1) ? 2'b10 : 2'b11;
      3'd1: begin
        if (tgt == 3'd0)      route_in = 2'b00;
        else if (tgt == 3'd2) route_in = 2'b01;
        else                  route_in = 2'b11;
      end
      3'd2: begin
        if (tgt == 3'd3)      route_in = 2'b11;
        else if (tgt == 3'd4) route_in = 2'b01;
        else                  route_in = 2'b00;
      end
      3'd3: route_in = (tgt == 3'd2) ? 2'b00 : 2'b10;
      3'd4: route_in = 2'b10;
      default: route_in = 2'b00;
    endcase
  endfunction

  // Model FSM: returns {next_state, mealy_out}.
  function automatic logic [4:0] trans(input logic [2:0] s, input logic [1:0] in);
    trans = {3'd0, 2'b00};
    case (s)
      3'd0: case (in)
        2'b00: trans = {3'd0, 2'b01};
        2'b01: trans = {3'd0, 2'b00};
        2'b10: trans = {3'd1, 2'b01};
        default: trans = {3'd2, 2'b00};
      endcase
      3'd1: case (in)
        2'b00: trans = {3'd0, 2'b11};
        2'b01: trans = {3'd2, 2'b11};
        2'b10: trans = {3'd1, 2'b10};
        default: trans = {3'd3, 2'b10};
      endcase
      3'd2: case (in)
        2'b00: trans = {3'd0, 2'b00};
        2'b01: trans = {3'd4, 2'b01};
        2'b10: trans = {3'd2, 2'b00};
        default: trans = {3'd3, 2'b00};
      endcase
      3'd3: case (in)
        2'b00: trans = {3'd2, 2'b11};
        2'b01: trans = {3'd4, 2'b01};
        2'b10: trans = {3'd4, 2'b01};
        default: trans = {3'd4, 2'b11};
      endcase
      3'd4: case (in)
        2'b00: trans = {3'd4, 2'b00};
        2'b01: trans = {3'd0, 2'b00};
        2'b10: trans = {3'd0, 2'b10};
        default: trans = {3'd4, 2'b11};
      endcase
      default: trans = {3'd0, 2'b00};
    endcase
  endfunction

  ctrl_e             ctrl_q, ctrl_d;
  logic [2:0]        model_q, model_d;
  logic [2:0]        tgt_q, tgt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              mismatch_q, mismatch_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [1:0]        exp_out;

  always_comb begin
    ctrl_d     = ctrl_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    done_d     = 1'b0;
    cmd_err_d  = 1'b0;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    fsm_input  = hold_in(model_q);
    case (ctrl_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_target <= 3'd4) begin
            tgt_d  = cmd_target;
            step_d = '0;
            ctrl_d = STEER;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      STEER: begin
        busy = 1'b1;
        if (model_q == tgt_q) begin
          ctrl_d = IDLE;
          done_d = 1'b1;
        end else begin
          fsm_input = route_in(model_q, tgt_q);
          step_d    = step_q + 1'b1;
        end
      end
      default: ctrl_d = IDLE;
    endcase

    {model_d, exp_out} = trans(model_q, fsm_input);
    mismatch_d = (fsm_output != exp_out);
    err_d      = err_q;
    if (mismatch_d && (err_q != {CNT_W{1'b1}}))
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= IDLE;
      model_q    <= 3'd0;
      tgt_q      <= 3'd0;
      step_q     <= '0;
      done_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      model_q    <= model_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      done_q     <= done_d;
      cmd_err_q  <= cmd_err_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  assign done       = done_q;
  assign step_count = step_q;
  assign cmd_err    = cmd_err_q;
  assign mismatch   = mismatch_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_fsm_seq_driver.sv
// Directed bench for fsm_seq_driver. A behavioural copy of the controlled
// FSM answers fsm_input; its output can be overridden to inject errors.
module tb_fsm_seq_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_target;
  logic [1:0] fsm_input;
  logic [1:0] fsm_output;
  logic       busy, done, cmd_err, mismatch;
  logic [1:0] step_count;
  logic [7:0] err_count;

  int passed = 0;
  int total  = 0;

  logic       force_en = 1'b0;
  logic [1:0] force_val = 2'b00;
  logic [2:0] fs, fs_nxt;
  logic [1:0] fs_out;

  always #5 clk = ~clk;

  fsm_seq_driver #(.CNT_W(8), .STEP_W(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .fsm_input(fsm_input), .fsm_output(fsm_output),
    .busy(busy), .done(done), .step_count(step_count), .cmd_err(cmd_err),
    .mismatch(mismatch), .err_count(err_count)
  );

  // Controlled FSM (environment), reset on the same edge as the driver.
  always_comb begin
    fs_nxt = 3'd0;
    fs_out = 2'b00;
    case ({fs, fsm_input})
      5'b000_00: begin fs_nxt = 3'd0; fs_out = 2'b01; end
      5'b000_01: begin fs_nxt = 3'd0; fs_out = 2'b00; end
      5'b000_10: begin fs_nxt = 3'd1; fs_out = 2'b01; end
      5'b000_11: begin fs_nxt = 3'd2; fs_out = 2'b00; end
      5'b001_00: begin fs_nxt = 3'd0; fs_out = 2'b11; end
      5'b001_01: begin fs_nxt = 3'd2; fs_out = 2'b11; end
      5'b001_10: begin fs_nxt = 3'd1; fs_out = 2'b10; end
      5'b001_11: begin fs_nxt = 3'd3; fs_out = 2'b10; end
      5'b010_00: begin fs_nxt = 3'd0; fs_out = 2'b00; end
      5'b010_01: begin fs_nxt = 3'd4; fs_out = 2'b01; end
      5'b010_10: begin fs_nxt = 3'd2; fs_out = 2'b00; end
      5'b010_11: begin fs_nxt = 3'd3; fs_out = 2'b00; end
      5'b011_00: begin fs_nxt = 3'd2; fs_out = 2'b11; end
      5'b011_01: begin fs_nxt = 3'd4; fs_out = 2'b01; end
      5'b011_10: begin fs_nxt = 3'd4; fs_out = 2'b01; end
      5'b011_11: begin fs_nxt = 3'd4; fs_out = 2'b11; end
      5'b100_00: begin fs_nxt = 3'd4; fs_out = 2'b00; end
      5'b100_01: begin fs_nxt = 3'd0; fs_out = 2'b00; end
      5'b100_10: begin fs_nxt = 3'd0; fs_out = 2'b10; end
      5'b100_11: begin fs_nxt = 3'd4; fs_out = 2'b11; end
      default:   begin fs_nxt = 3'd0; fs_out = 2'b00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) fs <= 3'd0;
    else       fs <= fs_nxt;
  end

  assign fsm_output = force_en ? force_val : fs_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait for done; lat = cycles from accept edge.
  task automatic run_cmd(input logic [2:0] t, output int lat);
    cmd_target = t;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_target = 3'd0;
    repeat (2) tick();
    reset = 1'b0;
    total++;
    if ({cmd_ready, busy, done, cmd_err, mismatch} !== 5'b10000) $display("FAIL reset_ctl got %b want 10000", {cmd_ready, busy, done, cmd_err, mismatch});
    else passed++;
    total++;
    if ({fsm_input, step_count, err_count} !== 12'h000) $display("FAIL reset_vals in=%b step=%0d err=%0d want 0/0/0", fsm_input, step_count, err_count);
    else passed++;
  endtask

  task automatic test_steer_s4();
    cmd_target = 3'd4; cmd_valid = 1'b1;
    tick();
    cmd_target = 3'd0;  // still valid while busy: must be ignored
    total++;
    if ({cmd_ready, busy, fsm_input} !== 4'b0111) $display("FAIL s4_hop1 ready/busy/in=%b want 0111", {cmd_ready, busy, fsm_input});
    else passed++;
    tick();
    total++;
    if (fsm_input !== 2'b01) $display("FAIL s4_hop2 in=%b want 01", fsm_input);
    else passed++;
    cmd_valid = 1'b0;
    tick();
    total++;
    if ({fsm_input, done, busy} !== 4'b0001) $display("FAIL s4_arrive in/done/busy=%b want 0001", {fsm_input, done, busy});
    else passed++;
    tick();
    total++;
    if ({done, cmd_ready, busy, step_count, err_count, mismatch} !== {3'b110, 2'd2, 8'd0, 1'b0})
      $display("FAIL s4_done done/ready/busy=%b step=%0d err=%0d mm=%b want 110/2/0/0", {done, cmd_ready, busy}, step_count, err_count, mismatch);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL s4_done_pulse done=%b want 0", done);
    else passed++;
  endtask

  task automatic test_route_s4_s3();
    logic [1:0] exp_seq [3];
    exp_seq = '{2'b10, 2'b11, 2'b11};
    cmd_target = 3'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (fsm_input !== exp_seq[i]) $display("FAIL s3_hop%0d in=%b want %b", i, fsm_input, exp_seq[i]);
      else passed++;
      tick();
    end
    total++;
    if ({fsm_input, busy, done} !== 4'b0010) $display("FAIL s3_arrive in/busy/done=%b want 0010", {fsm_input, busy, done});
    else passed++;
    tick();
    // done 5 cycles after accept; idling in S3 has already moved to S2 (hold 10)
    total++;
    if ({done, step_count, fsm_input} !== {1'b1, 2'd3, 2'b10}) $display("FAIL s3_done done=%b step=%0d in=%b want 1/3/10", done, step_count, fsm_input);
    else passed++;
  endtask

  task automatic test_no_move();
    int lat;
    run_cmd(3'd4, lat);  // S2 -> S4, one hop
    total++;
    if (lat !== 3) $display("FAIL s2_s4_latency got %0d want 3", lat);
    else passed++;
    cmd_target = 3'd4; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({busy, done, fsm_input} !== 4'b1000) $display("FAIL nomove_c1 busy/done/in=%b want 1000", {busy, done, fsm_input});
    else passed++;
    tick();
    total++;
    if ({done, step_count} !== {1'b1, 2'd0}) $display("FAIL nomove_done done=%b step=%0d want 1/0", done, step_count);
    else passed++;
  endtask

  task automatic test_mismatch();
    int lat;
    run_cmd(3'd0, lat);  // S4 -> S0, one hop
    total++;
    if (lat !== 3) $display("FAIL s4_s0_latency got %0d want 3", lat);
    else passed++;
    // idle in S0: input 00, expected output 01
    force_val = 2'b10; force_en = 1'b1;
    tick();
    force_en = 1'b0;
    total++;
    if ({mismatch, err_count} !== {1'b1, 8'd1}) $display("FAIL mm_single mm=%b err=%0d want 1/1", mismatch, err_count);
    else passed++;
    tick();
    total++;
    if ({mismatch, err_count} !== {1'b0, 8'd1}) $display("FAIL mm_clear mm=%b err=%0d want 0/1", mismatch, err_count);
    else passed++;
    force_en = 1'b1;
    repeat (300) tick();
    force_en = 1'b0;
    tick();
    total++;
    if ({mismatch, err_count} !== {1'b0, 8'd255}) $display("FAIL mm_saturate mm=%b err=%0d want 0/255", mismatch, err_count);
    else passed++;
  endtask

  task automatic test_illegal();
    cmd_target = 3'd6; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({cmd_err, cmd_ready, busy, fsm_input} !== 5'b11000) $display("FAIL illegal_pulse err/ready/busy/in=%b want 11000", {cmd_err, cmd_ready, busy, fsm_input});
    else passed++;
    tick();
    total++;
    if ({cmd_err, done, step_count, fs} !== {2'b00, 2'd1, 3'd0}) $display("FAIL illegal_after err/done=%b step=%0d state=%0d want 00/1/0", {cmd_err, done}, step_count, fs);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw;
    run_cmd(3'd4, lat);  // S0 -> S4, two hops
    total++;
    if (lat !== 4) $display("FAIL s0_s4_latency got %0d want 4", lat);
    else passed++;
    cmd_target = 3'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();  // now driving the second hop
    total++;
    if ({busy, fsm_input} !== 3'b111) $display("FAIL mid_hop2 busy/in=%b want 111", {busy, fsm_input});
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({cmd_ready, busy, done, cmd_err, mismatch, fsm_input} !== 7'b1000000) $display("FAIL mid_reset_ctl got %b want 1000000", {cmd_ready, busy, done, cmd_err, mismatch, fsm_input});
    else passed++;
    total++;
    if ({step_count, err_count} !== 10'd0) $display("FAIL mid_reset_cnt step=%0d err=%0d want 0/0", step_count, err_count);
    else passed++;
    saw = 1'b0;
    repeat (6) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    total++;
    if (saw) $display("FAIL mid_reset_nodone saw done/busy=1 want 0");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_steer_s4();
    test_route_s4_s3();
    test_no_move();
    test_mismatch();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
